// File: rtl/freq_meas_pkg.sv
// Shared types for the reciprocal frequency counter measurement sequencer.
// Result records are sized by MEAS_CNT_W for downstream consumers at the default width.
package freq_meas_pkg;

  localparam int MEAS_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meas_state_t;

  typedef struct packed {
    logic [MEAS_CNT_W-1:0] nx;
    logic [MEAS_CNT_W-1:0] ns;
    logic                  timeout;
  } meas_res_t;

  function automatic logic state_busy(input meas_state_t s);
    return (s == ARM) || (s == GATE);
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_edge_sync.sv
// Synchronizes the asynchronous measured signal into clk_fs and emits a one-cycle
// pulse on each real 0->1 transition.
module fx_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_fs,
  input  logic rst,
  input  logic fx_in,
  output logic fx_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], fx_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // Reset high so a signal already high at reset release is not mistaken for an edge.
  always_ff @(posedge clk_fs) begin
    if (rst) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign fx_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gate-window sequencer: opens and closes on synchronized fx edges, counts fx periods
// and reference cycles across the window, and hands the raw counts out via valid/ready.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk_fs,
  input  logic             rst,
  input  logic             fx_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_nx,
  output logic [CNT_W-1:0] res_ns,
  output logic             res_timeout
);

  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("GATE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES <= GATE_CYCLES) begin : g_bad_tmo_order
    $error("TIMEOUT_CYCLES must exceed GATE_CYCLES");
  end
  if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_tmo_width
    $error("TIMEOUT_CYCLES must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] GATE_LIM = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] ns_q, ns_d;
  logic [CNT_W-1:0] nx_q, nx_d;
  logic [CNT_W-1:0] res_nx_q, res_nx_d;
  logic [CNT_W-1:0] res_ns_q, res_ns_d;
  logic             res_to_q, res_to_d;

  logic             fx_rise;
  logic [CNT_W-1:0] tmo_inc, ns_inc, nx_inc;
  logic             arm_expire, gate_close, gate_expire;

  fx_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_fs  (clk_fs),
    .rst     (rst),
    .fx_in   (fx_in),
    .fx_rise (fx_rise)
  );

  always_comb begin
    tmo_inc     = tmo_q + 1'b1;
    ns_inc      = ns_q + 1'b1;
    nx_inc      = nx_q + CNT_W'(fx_rise);
    arm_expire  = (tmo_inc == TMO_LIM);
    gate_close  = fx_rise && (ns_inc >= GATE_LIM);
    gate_expire = (ns_inc == TMO_LIM);
  end

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A closing edge wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM: begin
        if (fx_rise)         state_d = GATE;
        else if (arm_expire) state_d = DONE;
      end
      GATE: if (gate_close || gate_expire) state_d = DONE;
      DONE: if (res_ready) state_d = cont ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = state_busy(state_q);
    res_valid = (state_q == DONE);
  end

  always_comb begin
    tmo_d    = tmo_q;
    ns_d     = ns_q;
    nx_d     = nx_q;
    res_nx_d = res_nx_q;
    res_ns_d = res_ns_q;
    res_to_d = res_to_q;
    case (state_q)
      IDLE: tmo_d = '0;
      ARM: begin
        if (fx_rise) begin
          ns_d = '0;
          nx_d = '0;
        end else begin
          tmo_d = tmo_inc;
          if (arm_expire) begin
            res_nx_d = '0;
            res_ns_d = '0;
            res_to_d = 1'b1;
          end
        end
      end
      GATE: begin
        ns_d = ns_inc;
        nx_d = nx_inc;
        if (gate_close) begin
          res_nx_d = nx_inc;
          res_ns_d = ns_inc;
          res_to_d = 1'b0;
        end else if (gate_expire) begin
          res_nx_d = nx_inc;
          res_ns_d = TMO_LIM;
          res_to_d = 1'b1;
        end
      end
      DONE: tmo_d = '0;
      default: tmo_d = '0;
    endcase
  end

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      tmo_q    <= '0;
      ns_q     <= '0;
      nx_q     <= '0;
      res_nx_q <= '0;
      res_ns_q <= '0;
      res_to_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      ns_q     <= ns_d;
      nx_q     <= nx_d;
      res_nx_q <= res_nx_d;
      res_ns_q <= res_ns_d;
      res_to_q <= res_to_d;
    end
  end

  assign res_nx      = res_nx_q;
  assign res_ns      = res_ns_q;
  assign res_timeout = res_to_q;

endmodule
